// File: rtl/frogger_game_ctrl.sv
// Frogger game sequencer: start/end of game, per-frame death/score/timeout decisions, score, lives and respawn.
// All outputs are registered and change one cycle after the triggering input; reset asserts asynchronously.
module frogger_game_ctrl #(
  parameter int c_START_LIVES  = 3,
  parameter int c_SCORE_LIMIT  = 99,
  parameter int c_HOME_ROW     = 0,
  parameter int c_ROUND_FRAMES = 1800,
  parameter int c_HOLD_FRAMES  = 60
) (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic        i_Game_Start,
  input  logic        i_Frame_Tick,
  input  logic        i_Collision,
  input  logic [5:0]  i_Frogger_Y,
  output logic [2:0]  o_State,
  output logic        o_Game_Active,
  output logic        o_Frog_Respawn,
  output logic [6:0]  o_Score,
  output logic [1:0]  o_Lives,
  output logic        o_Win,
  output logic [10:0] o_Time_Left
);

  localparam int HW = (c_HOLD_FRAMES < 1) ? 1 : $clog2(c_HOLD_FRAMES + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_HIT    = 3'd2,
    ST_SCORED = 3'd3,
    ST_OVER   = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [6:0]     score_q, score_d;
  logic [1:0]     lives_q, lives_d;
  logic           win_q, win_d;
  logic [10:0]    time_q, time_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic           respawn_q, respawn_d;
  logic           start_prev_q;
  logic           start_edge;
  logic [1:0]     lives_dec;
  logic           hold_done_over;

  assign start_edge = i_Game_Start & ~start_prev_q;
  assign lives_dec  = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
  // Leaving HIT/SCORED ends the game when no lives are left or the winning score was reached.
  assign hold_done_over = (state_q == ST_HIT)    ? (lives_q == 2'd0)
                                                 : (score_q == 7'(c_SCORE_LIMIT));

  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    lives_d   = lives_q;
    win_d     = win_q;
    time_d    = time_q;
    hold_d    = hold_q;
    respawn_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_edge) begin
          score_d   = 7'd0;
          lives_d   = 2'(c_START_LIVES);
          win_d     = 1'b0;
          time_d    = 11'(c_ROUND_FRAMES);
          state_d   = ST_RUN;
          respawn_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (i_Collision) begin
          state_d = ST_HIT;
          lives_d = lives_dec;
          hold_d  = HW'(c_HOLD_FRAMES);
        end else if (i_Frogger_Y == 6'(c_HOME_ROW)) begin
          state_d = ST_SCORED;
          score_d = (score_q >= 7'(c_SCORE_LIMIT)) ? 7'(c_SCORE_LIMIT) : score_q + 7'd1;
          hold_d  = HW'(c_HOLD_FRAMES);
        end else if (i_Frame_Tick) begin
          if (time_q == 11'd1) begin
            state_d = ST_HIT;
            lives_d = lives_dec;
            hold_d  = HW'(c_HOLD_FRAMES);
          end else begin
            time_d = time_q - 11'd1;
          end
        end
      end
      ST_HIT, ST_SCORED: begin
        if (hold_q == '0) begin
          if (hold_done_over) begin
            state_d = ST_OVER;
            win_d   = (state_q == ST_SCORED);
          end else begin
            state_d   = ST_RUN;
            time_d    = 11'(c_ROUND_FRAMES);
            respawn_d = 1'b1;
          end
        end else if (i_Frame_Tick) begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Start-edge history resets to 1 so a button held through reset cannot start a game.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q      <= ST_IDLE;
      score_q      <= 7'd0;
      lives_q      <= 2'd0;
      win_q        <= 1'b0;
      time_q       <= 11'd0;
      hold_q       <= '0;
      respawn_q    <= 1'b0;
      start_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      win_q        <= win_d;
      time_q       <= time_d;
      hold_q       <= hold_d;
      respawn_q    <= respawn_d;
      start_prev_q <= i_Game_Start;
    end
  end

  assign o_State        = state_q;
  assign o_Game_Active  = (state_q == ST_RUN);
  assign o_Frog_Respawn = respawn_q;
  assign o_Score        = score_q;
  assign o_Lives        = lives_q;
  assign o_Win          = win_q;
  assign o_Time_Left    = time_q;

endmodule

// File: tb/tb_frogger_game_ctrl.sv
// Bench for frogger_game_ctrl: directed game walk-through plus random play against a rule-level game model.
module tb_frogger_game_ctrl;

  localparam int LIVES = 2;
  localparam int LIMIT = 3;
  localparam int HOME  = 0;
  localparam int ROUND = 10;
  localparam int HOLD  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, tick, coll;
  logic [5:0]  fy;
  logic [2:0]  o_state;
  logic        o_active, o_resp, o_win;
  logic [6:0]  o_score;
  logic [1:0]  o_lives;
  logic [10:0] o_time;

  int n_checks = 0;
  int n_errors = 0;

  // Game model: phase names follow the game rules, values are plain integers.
  int  m_phase;   // 0 idle, 1 running, 2 hit, 3 scored, 4 over
  int  m_score, m_lives, m_win, m_time, m_frozen, m_resp, m_btn_last;

  always #20 clk = ~clk;

  frogger_game_ctrl #(
    .c_START_LIVES (LIVES),
    .c_SCORE_LIMIT (LIMIT),
    .c_HOME_ROW    (HOME),
    .c_ROUND_FRAMES(ROUND),
    .c_HOLD_FRAMES (HOLD)
  ) dut (
    .i_Clk         (clk),
    .i_Rst_L       (rst_n),
    .i_Game_Start  (start),
    .i_Frame_Tick  (tick),
    .i_Collision   (coll),
    .i_Frogger_Y   (fy),
    .o_State       (o_state),
    .o_Game_Active (o_active),
    .o_Frog_Respawn(o_resp),
    .o_Score       (o_score),
    .o_Lives       (o_lives),
    .o_Win         (o_win),
    .o_Time_Left   (o_time)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_score = 0; m_lives = 0; m_win = 0; m_time = 0;
    m_frozen = 0; m_resp = 0; m_btn_last = 1;
  endtask

  task automatic new_game();
    m_score = 0; m_lives = LIVES; m_win = 0; m_time = ROUND;
    m_phase = 1; m_resp = 1;
  endtask

  task automatic lose_life();
    if (m_lives > 0) m_lives--;
    m_phase = 2; m_frozen = HOLD;
  endtask

  task automatic model_frame(input int b, input int t, input int c, input int y);
    bit pressed;
    pressed = (b == 1) && (m_btn_last == 0);
    m_btn_last = b;
    m_resp = 0;
    if (m_phase == 0 || m_phase == 4) begin
      if (pressed) new_game();
    end else if (m_phase == 1) begin
      if (c == 1) lose_life();
      else if (y == HOME) begin
        m_score = (m_score + 1 > LIMIT) ? LIMIT : m_score + 1;
        m_phase = 3; m_frozen = HOLD;
      end else if (t == 1) begin
        if (m_time == 1) lose_life();
        else m_time--;
      end
    end else begin
      if (m_frozen == 0) begin
        if ((m_phase == 2 && m_lives == 0) || (m_phase == 3 && m_score == LIMIT)) begin
          m_win = (m_phase == 3);
          m_phase = 4;
        end else begin
          m_phase = 1; m_time = ROUND; m_resp = 1;
        end
      end else if (t == 1) begin
        m_frozen--;
      end
    end
  endtask

  task automatic compare_all();
    chk("state",   int'(o_state),  m_phase);
    chk("active",  int'(o_active), (m_phase == 1) ? 1 : 0);
    chk("respawn", int'(o_resp),   m_resp);
    chk("score",   int'(o_score),  m_score);
    chk("lives",   int'(o_lives),  m_lives);
    chk("win",     int'(o_win),    m_win);
    chk("time",    int'(o_time),   m_time);
  endtask

  task automatic cyc(input logic b, input logic t, input logic c, input logic [5:0] y);
    @(negedge clk);
    start = b; tick = t; coll = c; fy = y;
    @(posedge clk);
    model_frame(int'(b), int'(t), int'(c), int'(y));
    #1;
    compare_all();
  endtask

  task automatic finish_hold();
    cyc(0, 1, 0, 6'd5);
    cyc(0, 1, 0, 6'd5);
    cyc(0, 0, 0, 6'd5);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; tick = 1'b0; coll = 1'b0; fy = 6'd5;
    model_reset();
    #50;
    compare_all();

    // Button held across reset release must not start a game.
    @(negedge clk); rst_n = 1'b1;
    repeat (3) cyc(1, 0, 0, 6'd5);
    chk("held_start_idle", int'(o_state), 0);
    cyc(0, 0, 0, 6'd5);
    cyc(1, 0, 0, 6'd5);
    chk("start_state", int'(o_state), 1);
    chk("start_lives", int'(o_lives), 2);
    chk("start_time", int'(o_time), 10);
    chk("start_resp", int'(o_resp), 1);
    cyc(0, 0, 0, 6'd5);
    chk("resp_one_cycle", int'(o_resp), 0);

    // Reach home, hold, respawn.
    cyc(0, 0, 0, 6'd0);
    chk("home_state", int'(o_state), 3);
    chk("home_score", int'(o_score), 1);
    finish_hold();
    chk("home_back_run", int'(o_state), 1);
    chk("home_resp", int'(o_resp), 1);
    chk("home_time", int'(o_time), 10);

    // Collision wins over home.
    cyc(0, 0, 1, 6'd0);
    chk("coll_home_state", int'(o_state), 2);
    chk("coll_home_lives", int'(o_lives), 1);
    chk("coll_home_score", int'(o_score), 1);
    finish_hold();

    // Timeout on the 10th tick, last life, game over.
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 6'd5);
    chk("timeout_state", int'(o_state), 2);
    chk("timeout_lives", int'(o_lives), 0);
    finish_hold();
    chk("over_state", int'(o_state), 4);
    chk("over_win", int'(o_win), 0);
    cyc(0, 0, 0, 6'd5);
    cyc(1, 0, 0, 6'd5);
    chk("restart_state", int'(o_state), 1);
    chk("restart_lives", int'(o_lives), 2);
    chk("restart_score", int'(o_score), 0);

    // Three scores win the game; collision afterwards is ignored.
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 6'd0);
      finish_hold();
    end
    chk("win_state", int'(o_state), 4);
    chk("win_flag", int'(o_win), 1);
    chk("win_score", int'(o_score), 3);
    cyc(0, 0, 1, 6'd0);
    chk("over_coll_lives", int'(o_lives), 2);
    chk("over_coll_state", int'(o_state), 4);

    // Random play.
    for (int i = 0; i < 4000; i++) begin
      logic b, t, c;
      logic [5:0] y;
      b = ($urandom_range(0, 15) == 0);
      t = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 19) == 0);
      y = ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      cyc(b, t, c, y);
    end

    // Reset in the middle of a hit: immediate, no clock needed.
    cyc(0, 0, 0, 6'd5);
    cyc(1, 0, 0, 6'd5);
    if (o_state != 3'd1) cyc(0, 0, 0, 6'd5);
    cyc(0, 0, 0, 6'd5);
    while (m_phase != 1 && m_phase != 0 && m_phase != 4) cyc(0, 1, 0, 6'd5);
    if (m_phase != 1) begin
      cyc(0, 0, 0, 6'd5);
      cyc(1, 0, 0, 6'd5);
    end
    cyc(0, 0, 1, 6'd5);
    chk("pre_reset_hit", int'(o_state), 2);
    @(negedge clk);
    #5;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk); #1;
    chk("reset_no_resp", int'(o_resp), 0);
    chk("reset_hold_state", int'(o_state), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
